dmem_responder: RTL and testbench

//  Memory-side responder for the core's data-memory port (rd/wr/addr/wr_data/rd_data).

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_if.sv | 16 +
 rtl/dmem_byte_ram.sv | 20 ++
 rtl/dmem_responder.sv | 92 +++++++++
 tb/tb_dmem_responder.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state type, RV32 funct3 encodings and access-legality helpers
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  // Stores only accept the signed encodings; loads also accept the unsigned ones.
  function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (!wr && ((f3 == F3_BU) || (f3 == F3_HU)));
  endfunction
  // f3[1:0] encodes the access size for every legal funct3.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    return ((f3[1:0] == 2'b01) && lane[0]) || ((f3[1:0] == 2'b10) && (lane != 2'b00));
  endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: core data-memory port bundle
//   master (core):      drives req_rd/req_wr/req_addr/req_funct3/req_wdata, sees req_ready and rsp_*
//   slave (responder):  sees the request, drives req_ready/rsp_valid/rsp_rdata/rsp_err
interface dmem_if #(parameter int ADDR_W = 9, parameter int DATA_W = 32);
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_funct3;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  modport master(output req_rd, req_wr, req_addr, req_funct3, req_wdata, input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input req_rd, req_wr, req_addr, req_funct3, req_wdata, output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_byte_ram.sv
// dmem_byte_ram: four byte-lane RAM, per-lane write enables, asynchronous word read
//   clk    in  write clock
//   we     in  per-lane byte enables
//   idx    in  word index (shared by read and write)
//   wdata  in  lane-aligned write data
//   rdata  out word at idx
module dmem_byte_ram #(parameter int ADDR_W = 9) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-3:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) if (we[l]) mem[idx] <= wdata[8*l +: 8];
    assign rdata[8*l +: 8] = mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: RV32 load/store responder with configurable wait states over a byte RAM
//   clk    in  clock
//   reset  in  asynchronous active-low reset
//   bus    slave side of dmem_if: request in, req_ready/rsp_valid/rsp_rdata/rsp_err out
module dmem_responder import dmem_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);
  localparam logic [3:0] LAST = 4'(WAIT_STATES - 1);
  dmem_state_t       state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q, a;
  logic [2:0]        f3_q, f3;
  logic [DATA_W-1:0] wd_q, word, sh, ld, rsp_d;
  logic              wr_q, err_q, idle, wr, err_c, err;
  logic [3:0]        be, we;
  // In IDLE the live request is used so a zero-wait response can be formed on the accept edge.
  assign idle  = state == IDLE;
  assign a     = idle ? bus.req_addr : addr_q;
  assign f3    = idle ? bus.req_funct3 : f3_q;
  assign wr    = idle ? bus.req_wr : wr_q;
  assign err_c = (bus.req_rd & bus.req_wr) | ~f3_legal(bus.req_wr, bus.req_funct3) | misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign err   = idle ? err_c : err_q;
  assign sh    = word >> {a[1:0], 3'b000};
  assign ld    = f3 == F3_B  ? {{(DATA_W-8){sh[7]}}, sh[7:0]} :
                 f3 == F3_H  ? {{(DATA_W-16){sh[15]}}, sh[15:0]} :
                 f3 == F3_BU ? {{(DATA_W-8){1'b0}}, sh[7:0]} :
                 f3 == F3_HU ? {{(DATA_W-16){1'b0}}, sh[15:0]} : sh;
  assign rsp_d = (err | wr) ? '0 : ld;
  assign be    = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] : f3_q[1:0] == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
  // Only a store in RESP writes, so the write lands on the edge that leaves RESP.
  assign we    = (state == RESP && wr_q && !err_q) ? be : 4'b0000;
  dmem_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk  (clk),
    .we   (we),
    .idx  (a[ADDR_W-1:2]),
    .wdata(wd_q << {addr_q[1:0], 3'b000}),
    .rdata(word)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      f3_q          <= '0;
      wd_q          <= '0;
      wr_q          <= 1'b0;
      err_q         <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_rd | bus.req_wr) begin
          addr_q        <= bus.req_addr;
          f3_q          <= bus.req_funct3;
          wd_q          <= bus.req_wdata;
          wr_q          <= bus.req_wr;
          err_q         <= err_c;
          bus.req_ready <= 1'b0;
          if (WAIT_STATES == 0) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= rsp_d;
            bus.rsp_err   <= err;
          end else state <= WAIT;
        end
        WAIT: if (cnt == LAST) begin
          cnt           <= '0;
          state         <= RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_rdata <= rsp_d;
          bus.rsp_err   <= err;
        end else cnt <= cnt + 4'd1;
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          bus.rsp_rdata <= '0;
          bus.rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven, hand-written and randomized checks of dmem_responder against a byte-array model
module tb_dmem_responder;
  import dmem_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  dmem_if #(.ADDR_W(9), .DATA_W(32)) bus ();
  dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_STATES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] mm [512];
  typedef struct {
    logic rd, wr;
    logic [2:0] f3;
    logic [8:0] a;
    logic [31:0] wd;
    logic e;
    logic [31:0] d;
  } vec_t;
  vec_t tbl [20];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  // Reference: an access is n bytes at byte address a, assembled little-endian.
  task automatic ref_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [8:0] a,
                        input logic [31:0] wd, output logic e, output logic [31:0] d);
    int n;
    logic sgn, ld_only;
    logic [31:0] acc;
    n = 0; sgn = 1'b0; ld_only = 1'b0;
    case (f3)
      3'd0: begin n = 1; sgn = 1'b1; end
      3'd1: begin n = 2; sgn = 1'b1; end
      3'd2: n = 4;
      3'd4: begin n = 1; ld_only = 1'b1; end
      3'd5: begin n = 2; ld_only = 1'b1; end
      default: n = 0;
    endcase
    e = (rd && wr) || n == 0 || (wr && ld_only) || (n != 0 && (int'(a) % n) != 0);
    d = 32'h0;
    if (!e && rd) begin
      acc = 32'h0;
      for (int k = 0; k < n; k++) acc = acc + (32'(mm[int'(a) + k]) << (8 * k));
      if (sgn && n < 4 && acc[8 * n - 1]) acc = acc - (32'd1 << (8 * n));
      d = acc;
    end
    if (!e && wr) for (int k = 0; k < n; k++) mm[int'(a) + k] = wd[8 * k +: 8];
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
    bus.req_rd = rd; bus.req_wr = wr; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
  endtask
  task automatic wait_ready();
    int g;
    g = 0;
    while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
  endtask
  // One transaction; lat counts falling edges after the accepting rising edge (0 = no response).
  task automatic xact(input logic rd, input logic wr, input logic [2:0] f3, input logic [8:0] a,
                      input logic [31:0] wd, output int lat, output logic [31:0] d, output logic e);
    @(negedge clk);
    drive(rd, wr, f3, a, wd);
    wait_ready();
    lat = 0; d = 'x; e = 'x;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (i == 1) begin bus.req_rd = 1'b0; bus.req_wr = 1'b0; end
      if (bus.rsp_valid) begin lat = i; d = bus.rsp_rdata; e = bus.rsp_err; end
    end
    if (lat != 0) begin
      @(negedge clk);
      check("valid_pulse", 32'(bus.rsp_valid), 32'd0);
    end
  endtask
  initial begin : main
    int lat;
    logic [31:0] d, md;
    logic e, me;
    logic [8:0] vmask, rmask;
    int vcnt;
    logic rd, wr;
    logic [2:0] f3;
    logic [8:0] a;
    logic [31:0] wd;
    tbl[0]  = '{1'b0, 1'b1, F3_W,  9'h004, 32'hDEADBEEF, 1'b0, 32'h00000000};
    tbl[1]  = '{1'b1, 1'b0, F3_W,  9'h004, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, F3_B,  9'h007, 32'h0,        1'b0, 32'hFFFFFFDE};
    tbl[3]  = '{1'b1, 1'b0, F3_BU, 9'h007, 32'h0,        1'b0, 32'h000000DE};
    tbl[4]  = '{1'b1, 1'b0, F3_H,  9'h006, 32'h0,        1'b0, 32'hFFFFDEAD};
    tbl[5]  = '{1'b1, 1'b0, F3_HU, 9'h004, 32'h0,        1'b0, 32'h0000BEEF};
    tbl[6]  = '{1'b0, 1'b1, F3_B,  9'h005, 32'h00000012, 1'b0, 32'h00000000};
    tbl[7]  = '{1'b1, 1'b0, F3_W,  9'h004, 32'h0,        1'b0, 32'hDEAD12EF};
    tbl[8]  = '{1'b1, 1'b0, F3_W,  9'h006, 32'h0,        1'b1, 32'h00000000};
    tbl[9]  = '{1'b0, 1'b1, F3_W,  9'h000, 32'h01234567, 1'b0, 32'h00000000};
    tbl[10] = '{1'b0, 1'b1, F3_H,  9'h003, 32'h0000FFFF, 1'b1, 32'h00000000};
    tbl[11] = '{1'b1, 1'b0, F3_W,  9'h000, 32'h0,        1'b0, 32'h01234567};
    tbl[12] = '{1'b1, 1'b1, F3_W,  9'h000, 32'hAAAAAAAA, 1'b1, 32'h00000000};
    tbl[13] = '{1'b1, 1'b0, F3_W,  9'h000, 32'h0,        1'b0, 32'h01234567};
    tbl[14] = '{1'b1, 1'b0, 3'b011, 9'h000, 32'h0,       1'b1, 32'h00000000};
    tbl[15] = '{1'b0, 1'b1, F3_BU, 9'h000, 32'h000000FF, 1'b1, 32'h00000000};
    tbl[16] = '{1'b1, 1'b0, F3_HU, 9'h001, 32'h0,        1'b1, 32'h00000000};
    tbl[17] = '{1'b1, 1'b0, F3_W,  9'h000, 32'h0,        1'b0, 32'h01234567};
    tbl[18] = '{1'b0, 1'b1, F3_W,  9'h008, 32'hCAFEF00D, 1'b0, 32'h00000000};
    tbl[19] = '{1'b1, 1'b0, F3_H,  9'h00A, 32'h0,        1'b0, 32'hFFFFCAFE};
    drive(1'b0, 1'b0, 3'b000, 9'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      xact(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, lat, d, e);
      ref_op(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, me, md);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_err", i), 32'(e), 32'(tbl[i].e));
      check($sformatf("v%0d_rdata", i), d, tbl[i].d);
    end
    // A load held continuously: accepted, then accepted again once req_ready returns.
    @(negedge clk);
    drive(1'b1, 1'b0, F3_W, 9'h004, 32'h0);
    wait_ready();
    vmask = '0; rmask = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      vmask[i] = bus.rsp_valid;
      rmask[i] = bus.req_ready;
      if (bus.rsp_valid) check($sformatf("hold_rdata_%0d", i), bus.rsp_rdata, 32'hDEAD12EF);
    end
    drive(1'b0, 1'b0, F3_W, 9'h004, 32'h0);
    check("hold_valid_cycles", 32'(vmask), 32'(9'b010001000));
    check("hold_ready_cycles", 32'(rmask), 32'(9'b100010000));
    // Reset during the wait states of a store: the store is dropped.
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, F3_W, 9'h008, 32'h11111111);
    wait_ready();
    @(negedge clk);
    drive(1'b0, 1'b0, F3_W, 9'h008, 32'h11111111);
    check("mid_busy", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_rdata", bus.rsp_rdata, 32'd0);
    check("mid_rst_err", 32'(bus.rsp_err), 32'd0);
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); vcnt += int'(bus.rsp_valid); end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); vcnt += int'(bus.rsp_valid); end
    check("mid_no_valid", 32'(vcnt), 32'd0);
    xact(1'b1, 1'b0, F3_W, 9'h008, 32'h0, lat, d, e);
    check("mid_lw_rdata", d, 32'hCAFEF00D);
    check("mid_lw_err", 32'(e), 32'd0);
    // Fill the whole RAM so the model knows every byte, then random traffic.
    for (int w = 0; w < 128; w++) begin
      wd = $urandom;
      xact(1'b0, 1'b1, F3_W, 9'(w * 4), wd, lat, d, e);
      ref_op(1'b0, 1'b1, F3_W, 9'(w * 4), wd, me, md);
      check($sformatf("fill%0d_err", w), 32'(e), 32'(me));
    end
    for (int t = 0; t < 250; t++) begin
      rd = 1'($urandom_range(0, 1));
      wr = !rd;
      if ($urandom_range(0, 9) == 0) begin rd = 1'b1; wr = 1'b1; end
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      a = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'b01) ? {a[1], 1'b0} : (f3[1:0] == 2'b10 ? 2'b00 : a[1:0]);
      wd = $urandom;
      xact(rd, wr, f3, a, wd, lat, d, e);
      ref_op(rd, wr, f3, a, wd, me, md);
      check($sformatf("rnd%0d_latency", t), 32'(lat), 32'd3);
      check($sformatf("rnd%0d_err", t), 32'(e), 32'(me));
      check($sformatf("rnd%0d_rdata", t), d, md);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end
endmodule
